// File: rtl/bpsk_pkg.sv
// Shared constants and state type for the BPSK demodulator.
package bpsk_pkg;

  localparam int WORD_W_DEF  = 18;
  localparam int SYM_LEN_DEF = 4;
  localparam int ERR_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bpsk_symbol_integrator.sv
// Correlates each sample with the carrier, integrates over one symbol and
// makes the majority decision on the symbol's last sample.
module bpsk_symbol_integrator #(
  parameter int SYM_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic bpsk_i,
  input  logic carrier_i,
  output logic bit_o,
  output logic bit_strobe_o,
  output logic mixed_o
);

  localparam int ACC_W = $clog2(SYM_LEN + 1);
  localparam int CNT_W = $clog2(SYM_LEN);

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_s, last_s;

  // Strict majority: a tie decides 0.
  function automatic logic majority(input logic [ACC_W-1:0] acc);
    logic [ACC_W:0] twice;
    twice = {acc, 1'b0};
    return twice > (ACC_W + 1)'(SYM_LEN);
  endfunction

  // Correlation, decision and next accumulator/sample-counter values.
  always_comb begin
    c_s          = ~(bpsk_i ^ carrier_i);
    acc_sum_s    = acc_q + ACC_W'(c_s);
    last_s       = en_i && (cnt_q == CNT_W'(SYM_LEN - 1));
    bit_strobe_o = last_s;
    bit_o        = majority(acc_sum_s);
    mixed_o      = (acc_sum_s != ACC_W'(0)) && (acc_sum_s != ACC_W'(SYM_LEN));
    if (clr_i) begin
      acc_d = ACC_W'(0);
      cnt_d = CNT_W'(0);
    end else if (en_i && last_s) begin
      acc_d = ACC_W'(0);
      cnt_d = CNT_W'(0);
    end else if (en_i) begin
      acc_d = acc_sum_s;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Integrator state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= ACC_W'(0);
      cnt_q <= CNT_W'(0);
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bpsk_demod.sv
// BPSK demodulator top: framing, LSB-first packing and valid/ready output hold.
// Optional non-unanimous symbol counter enabled by BPSK_DEMOD_ERRCNT_EN.
module bpsk_demod
  import bpsk_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int SYM_LEN = SYM_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bpsk_in,
  input  logic              carrier_ref,
  input  logic              in_valid,
  input  logic              read_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun,
  output logic              busy
`ifdef BPSK_DEMOD_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int BC_W = $clog2(WORD_W);

  state_e            state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d, data_q, data_d;
  logic              armed_q, armed_d, valid_q, valid_d;
  logic              ovr_q, ovr_d, busy_q, busy_d;
  logic              start_s, en_s, clr_s, bit_s, strobe_s, mixed_s;

  // armed_q blocks a frame already in flight when reset released.
  assign start_s = (state_q == IDLE) && in_valid && armed_q;
  assign en_s    = start_s || ((state_q == RX) && in_valid);
  assign clr_s   = (state_q == RX) && !in_valid;

  bpsk_symbol_integrator #(.SYM_LEN(SYM_LEN)) u_integ (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en_s),
    .clr_i        (clr_s),
    .bpsk_i       (bpsk_in),
    .carrier_i    (carrier_ref),
    .bit_o        (bit_s),
    .bit_strobe_o (strobe_s),
    .mixed_o      (mixed_s)
  );

  // Frame sequencing and bit packing.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    if (!in_valid) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
    case (state_q)
      IDLE: begin
        if (start_s) begin
          armed_d = 1'b0;
          state_d = RX;
        end else begin
          state_d = IDLE;
        end
      end
      RX: begin
        if (!in_valid) begin
          bit_cnt_d = BC_W'(0);
          state_d   = IDLE;
        end else if (strobe_s) begin
          sr_d = {bit_s, sr_q[WORD_W-1:1]};
          if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
            bit_cnt_d = BC_W'(0);
            state_d   = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      DONE:    state_d = IDLE;
      default: begin
        bit_cnt_d = BC_W'(0);
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output hold register: load, reload-on-read, or drop with overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (state_q == DONE) begin
      if (!valid_q || read_ready) begin
        data_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && read_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= BC_W'(0);
      sr_q      <= WORD_W'(0);
      armed_q   <= 1'b0;
      data_q    <= WORD_W'(0);
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

`ifdef BPSK_DEMOD_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_q, err_d;

  // Saturating count of non-unanimous symbol decisions.
  always_comb begin
    if (strobe_s && mixed_s) begin
      err_d = sat_inc(err_q);
    end else begin
      err_d = err_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= ERR_CNT_W'(0);
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  logic mixed_unused_s;
  assign mixed_unused_s = mixed_s;
`endif

endmodule
